// File: rtl/intxn_pkg.sv
// Purpose: shared types and constants for the multi-phase intersection controller.
// Contents: controller state enum, lamp bit offsets within a phase triple,
//           phase-index width, and a small max helper for width derivation.
package intxn_pkg;

  localparam int unsigned PHASE_W         = 2;
  localparam int unsigned LAMPS_PER_PHASE = 3;
  localparam int unsigned LAMP_RED        = 2;
  localparam int unsigned LAMP_YEL        = 1;
  localparam int unsigned LAMP_GRN        = 0;

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_ALL_RED = 2'd2
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/intxn_req_arbiter.sv
// Purpose: latches per-phase car requests and finds the next phase to serve,
//          searching round-robin from the phase after the active one.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_car_req           per-phase car detect
//   i_active            currently granted phase
//   i_green             controller is in GREEN (own-phase requests are dropped)
//   i_grant             controller is leaving ALL_RED this cycle
//   o_pending           latched, not-yet-served requests (registered)
//   o_next_phase_c      next phase to serve, or i_active when none is pending
//   o_other_pending_c   some phase other than i_active is pending
module intxn_req_arbiter
  import intxn_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PHASES-1:0] i_car_req,
  input  logic [PHASE_W-1:0]    i_active,
  input  logic                  i_green,
  input  logic                  i_grant,
  output logic [NUM_PHASES-1:0] o_pending,
  output logic [PHASE_W-1:0]    o_next_phase_c,
  output logic                  o_other_pending_c
);

  logic [NUM_PHASES-1:0]   r_pending;
  logic [NUM_PHASES-1:0]   w_active_oh;
  logic [NUM_PHASES-1:0]   w_set;
  logic [NUM_PHASES-1:0]   w_clr;
  logic [NUM_PHASES-1:0]   w_rot;
  logic [NUM_PHASES-1:0]   w_scan;
  logic [2*NUM_PHASES-1:0] w_dbl;
  logic                    w_found;
  logic [PHASE_W-1:0]      w_next;

  assign w_active_oh = NUM_PHASES'(1) << i_active;
  assign w_set       = i_car_req & ~(i_green ? w_active_oh : '0);

  // Rotate pending so bit k corresponds to phase (active+1+k) mod NUM_PHASES.
  assign w_dbl = {r_pending, r_pending} >> (32'(i_active) + 32'd1);
  assign w_rot = w_dbl[NUM_PHASES-1:0];

  // First set bit of the rotated vector is the round-robin winner.
  always_comb begin
    w_found = 1'b0;
    w_next  = i_active;
    w_scan  = w_rot;
    for (int unsigned k = 0; k < NUM_PHASES; k++) begin
      if (!w_found && w_scan[0]) begin
        w_found = 1'b1;
        w_next  = PHASE_W'((32'(i_active) + 32'd1 + k) % NUM_PHASES);
      end
      w_scan = w_scan >> 1;
    end
  end

  // Clear only fires as the winner enters GREEN, so it overrides a same-cycle set.
  assign w_clr = (i_grant && w_found) ? (NUM_PHASES'(1) << w_next) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending | w_set) & ~w_clr;
  end

  assign o_pending         = r_pending;
  assign o_next_phase_c    = w_next;
  assign o_other_pending_c = |(r_pending & ~w_active_oh);

endmodule

// File: rtl/multi_phase_intxn_ctrl.sv
// Purpose: multi-phase traffic intersection controller: GREEN/YELLOW/ALL_RED
//          sequencing with minimum green, gap-out extension and max-out, resting
//          in the current phase while no other phase is waiting.
// Ports:
//   clock         single rising-edge clock
//   reset_n       async active-low reset
//   car_req       per-phase car detect (debounced upstream)
//   lights_out    registered lamps, phase p: bit 3p+2 red, 3p+1 yellow, 3p green
//   active_phase  phase currently granted green or yellow
//   req_pending   latched, not-yet-served requests
module multi_phase_intxn_ctrl
  import intxn_pkg::*;
#(
  parameter int unsigned NUM_PHASES   = 2,
  parameter int unsigned MIN_GREEN    = 250_000_000,
  parameter int unsigned MAX_GREEN    = 1_000_000_000,
  parameter int unsigned GAP_TIME     = 100_000_000,
  parameter int unsigned YELLOW_TIME  = 150_000_000,
  parameter int unsigned ALL_RED_TIME = 50_000_000
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_PHASES-1:0]               car_req,
  output logic [LAMPS_PER_PHASE*NUM_PHASES-1:0] lights_out,
  output logic [PHASE_W-1:0]                  active_phase,
  output logic [NUM_PHASES-1:0]               req_pending
);

  localparam int unsigned LW    = LAMPS_PER_PHASE * NUM_PHASES;
  localparam int unsigned MAX_T = max_u(max_u(max_u(MIN_GREEN, MAX_GREEN),
                                              max_u(GAP_TIME, YELLOW_TIME)), ALL_RED_TIME);
  localparam int unsigned TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_M1 = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] GAP_M1 = TW'(GAP_TIME - 1);
  localparam logic [TW-1:0] YEL_M1 = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_M1  = TW'(ALL_RED_TIME - 1);

  state_t                r_state;
  logic [PHASE_W-1:0]    r_active;
  logic [TW-1:0]         r_timer;
  logic [TW-1:0]         r_gap;
  logic [LW-1:0]         r_lights;

  logic [NUM_PHASES-1:0] w_active_oh;
  logic                  w_own_req;
  logic                  w_other_pending;
  logic                  w_grant;
  logic                  w_go_yellow;
  logic [TW-1:0]         w_gap_inc;
  logic [PHASE_W-1:0]    w_next_phase;

  // Lamp pattern for a given state and active phase: one lamp lit per phase.
  function automatic logic [LW-1:0] lamps(input state_t st, input logic [PHASE_W-1:0] ph);
    logic [LW-1:0] v;
    logic [2:0]    lamp;
    v = '0;
    for (int unsigned p = 0; p < NUM_PHASES; p++) begin
      lamp = 3'b1 << LAMP_RED;
      if (st != ST_ALL_RED && ph == PHASE_W'(p))
        lamp = (st == ST_YELLOW) ? (3'b1 << LAMP_YEL) : (3'b1 << LAMP_GRN);
      v = v | (LW'(lamp) << (LAMPS_PER_PHASE * p));
    end
    return v;
  endfunction

  intxn_req_arbiter #(
    .NUM_PHASES (NUM_PHASES)
  ) u_arb (
    .clk               (clock),
    .rst_n             (reset_n),
    .i_car_req         (car_req),
    .i_active          (r_active),
    .i_green           (r_state == ST_GREEN),
    .i_grant           (w_grant),
    .o_pending         (req_pending),
    .o_next_phase_c    (w_next_phase),
    .o_other_pending_c (w_other_pending)
  );

  assign w_active_oh = NUM_PHASES'(1) << r_active;
  assign w_own_req   = |(car_req & w_active_oh);
  assign w_gap_inc   = (r_gap == GAP_M1) ? r_gap : r_gap + 1'b1;
  assign w_grant     = (r_state == ST_ALL_RED) && (r_timer == AR_M1);
  assign w_go_yellow = (r_state == ST_GREEN) && (r_timer >= MIN_M1) && w_other_pending &&
                       ((r_gap == GAP_M1) || (r_timer == MAX_M1));

  // Controller FSM; timers restart on every state entry and lamps are
  // computed from the next state so lights_out never lags the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_GREEN;
      r_active <= '0;
      r_timer  <= '0;
      r_gap    <= '0;
      r_lights <= lamps(ST_GREEN, '0);
    end else begin
      case (r_state)
        ST_GREEN: begin
          r_gap <= w_own_req ? '0 : w_gap_inc;
          if (w_go_yellow) begin
            r_state  <= ST_YELLOW;
            r_timer  <= '0;
            r_lights <= lamps(ST_YELLOW, r_active);
          end else if (r_timer != MAX_M1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_YELLOW: begin
          r_gap <= w_gap_inc;
          if (r_timer == YEL_M1) begin
            r_state  <= ST_ALL_RED;
            r_timer  <= '0;
            r_lights <= lamps(ST_ALL_RED, r_active);
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_ALL_RED: begin
          if (w_grant) begin
            // Gap restarts with the new green so extension is judged on that phase only.
            r_state  <= ST_GREEN;
            r_timer  <= '0;
            r_gap    <= '0;
            r_active <= w_next_phase;
            r_lights <= lamps(ST_GREEN, w_next_phase);
          end else begin
            r_timer <= r_timer + 1'b1;
            r_gap   <= w_gap_inc;
          end
        end
        default: begin
          r_state  <= ST_GREEN;
          r_timer  <= '0;
          r_gap    <= '0;
          r_lights <= lamps(ST_GREEN, r_active);
        end
      endcase
    end
  end

  assign lights_out   = r_lights;
  assign active_phase = r_active;

endmodule

// File: doc/multi_phase_intxn_ctrl.md
MULTI_PHASE_INTXN_CTRL -- requirements
Module: multi_phase_intxn_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PHASES, default 2: number of approach phases (legal 2..4), each with its own light group.
REQ-002 The block SHALL have parameter MIN_GREEN, default 250_000_000: minimum green time in clock cycles.
REQ-003 The block SHALL have parameter MAX_GREEN, default 1_000_000_000: maximum green time while another phase waits (cycles, at least MIN_GREEN).
REQ-004 The block SHALL have parameter GAP_TIME, default 100_000_000: own-phase idle cycles that end a green extension.
REQ-005 The block SHALL have parameters YELLOW_TIME, default 150_000_000, and ALL_RED_TIME, default 50_000_000, both in cycles and at least 1.
REQ-006 The block SHALL have port clock, input, 1 bit: single clock; all state on rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port car_req, input, NUM_PHASES bits: synchronous, active-high, one-cycle-or-longer car-detect per phase (already debounced upstream).
REQ-009 The block SHALL have port lights_out, output, 3*NUM_PHASES bits: for phase p, bit 3p+2 is red, 3p+1 is yellow, and 3p is green.
REQ-010 The block SHALL have port active_phase, output, 2 bits: index of the phase currently granted green or yellow.
REQ-011 The block SHALL have port req_pending, output, NUM_PHASES bits: latched, not-yet-served requests.

Function
REQ-012 The controller SHALL be an FSM with states GREEN, YELLOW and ALL_RED, and a state timer that clears on every state entry and increments by 1 each cycle.
REQ-013 lights_out SHALL be registered (no combinational path from car_req), with exactly one lamp lit per phase: active phase green in GREEN, yellow in YELLOW; all other phases red; every phase red in ALL_RED.
REQ-014 A car_req[p] high SHALL set req_pending[p] on the next edge, unless p is the active phase and the state is GREEN, in which case it is not latched.
REQ-015 Own-phase car_req in GREEN SHALL clear the gap counter; otherwise the gap counter increments each cycle, saturating at GAP_TIME-1.
REQ-016 GREEN SHALL transition to YELLOW when timer is at least MIN_GREEN-1, some other req_pending bit is set, and either gap counter equals GAP_TIME-1 or timer equals MAX_GREEN-1.
REQ-017 With no other phase pending, GREEN SHALL hold indefinitely (rest in current phase), with the timer saturating at MAX_GREEN-1.
REQ-018 YELLOW SHALL transition to ALL_RED when timer equals YELLOW_TIME-1.
REQ-019 ALL_RED SHALL transition to GREEN when timer equals ALL_RED_TIME-1.
REQ-020 On ALL_RED exit, the next phase SHALL be the first pending phase searching round-robin from active_phase+1 (mod NUM_PHASES); active_phase updates and that req_pending bit clears on the same edge.
REQ-021 If no phase is pending at ALL_RED exit (impossible by REQ-016, defensive), the block SHALL return GREEN to the same phase.
REQ-022 When car_req and the clear for the same bit occur in the same cycle, the clear SHALL win only if that phase is entering GREEN; otherwise the set wins.
REQ-023 Timer and gap counter widths SHALL be derived by $clog2 of the largest time parameter; no counter wraps.

Reset
REQ-024 While reset_n is low, the block SHALL hold: state GREEN, active_phase 0, timer 0, gap counter 0, req_pending all 0, lights_out phase 0 green and others red.
REQ-025 Reset asserted mid-YELLOW or mid-ALL_RED SHALL take effect immediately (asynchronously) with no lamp glitch beyond the reset value.
REQ-026 The first GREEN after reset release SHALL count MIN_GREEN from the first released edge.

Structure
REQ-027 Shared package intxn_pkg SHALL hold the state enum, the lamp bit offsets (RED=2, YEL=1, GRN=0) and the phase-index width.
REQ-028 Request latching plus the round-robin next-phase search SHALL be a sub-module intxn_req_arbiter; the FSM, timers and light decode SHALL stay in the top.

Verification (NUM_PHASES=2, MIN=8, MAX=20, GAP=4, YEL=3, AR=2)
REQ-029 Reset, no requests for 100 cycles -> lights_out=6'b100_001 throughout, active_phase=0.
REQ-030 car_req[1] pulse at cycle 2 -> YELLOW at timer 7 entry edge, 3 yellow cycles, 2 all-red (6'b100_100), then phase 1 green and req_pending=0.
REQ-031 car_req[1] at cycle 0 plus car_req[0] every 2 cycles -> green extended to MAX, yellow at timer 19.
REQ-032 NUM_PHASES=4, phase 0 green, car_req[3] and car_req[1] pulsed together -> phase 1 served first, then phase 3.
REQ-033 reset_n dropped in YELLOW -> same cycle lights_out returns to phase 0 green with req_pending cleared.
REQ-034 car_req[0] pulsed during phase 0 GREEN only -> req_pending stays 0, no phase change.
